// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR MAC scheduler.
// Holds the FSM state encoding, index-width constants and the round-robin
// pick function used by rr_arbiter.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    // Widest requester count the pick function supports.
    localparam int MAX_CH   = 8;
    localparam int DEF_TAPS = 20;
    localparam int TAP_W    = $clog2(DEF_TAPS);
    // MAC_LAT is at most 7, so three bits always hold the drain count.
    localparam int LAT_W    = 3;

    // Returns a one-hot vector for the first set bit of elig, searching
    // upward from ptr+1 and wrapping at n. Returns zero when elig is empty.
    function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] elig,
                                                  input logic [2:0]        ptr,
                                                  input int unsigned       n);
        logic [MAX_CH-1:0] pick;
        logic              found;
        int unsigned       idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i <= n && !found && elig[idx[2:0]]) begin
                pick[idx[2:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks one eligible requester starting
// just after the last winner, and reports the winner's index.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int PTR_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] elig,
    input  logic [PTR_W-1:0]    ptr,
    output logic [CHANNELS-1:0] pick,
    output logic [PTR_W-1:0]    pick_idx
);
    import fir_sched_pkg::*;

    // Widen to the package width, search, and trim back to CHANNELS bits.
    always_comb begin
        pick = CHANNELS'(rr_pick(MAX_CH'(elig), 3'(ptr), CHANNELS));
    end

    // Encode the one-hot winner so the pointer can remember it.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler sharing one complex MAC between CHANNELS FIR
// requesters. Grants a requester, issues taps 0..TAPS-1, waits MAC_LAT
// cycles for the sum, then strobes done once the owner's FIFO has room.
// Optional build macro FIR_SCHED_STATS_EN adds job_count and stall_cycles.
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int TAPS     = 20,
    parameter int MAC_LAT  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNELS-1:0]      req,
    input  logic [CHANNELS-1:0]      out_full,
    output logic [CHANNELS-1:0]      grant,
    output logic                     tap_valid,
    output logic [$clog2(TAPS)-1:0]  tap_idx,
    output logic                     acc_clr,
    output logic                     tap_last,
    output logic [CHANNELS-1:0]      done,
`ifdef FIR_SCHED_STATS_EN
    output logic [31:0]              job_count,
    output logic [31:0]              stall_cycles,
`endif
    output logic                     busy
);

    localparam int TW    = $clog2(TAPS);
    localparam int PTR_W = $clog2(CHANNELS);
    localparam logic [TW-1:0]    LAST_IDX = TW'(TAPS - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    sched_state_t         state_q, state_d;
    logic [CHANNELS-1:0]  grant_q, grant_d;
    logic                 tap_valid_q, tap_valid_d;
    logic [TW-1:0]        tap_idx_q, tap_idx_d;
    logic                 acc_clr_q, acc_clr_d;
    logic                 tap_last_q, tap_last_d;
    logic                 busy_q, busy_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [CHANNELS-1:0]  elig;
    logic [CHANNELS-1:0]  pick;
    logic [PTR_W-1:0]     pick_idx;
    logic                 owner_full;

    assign elig       = req & ~out_full;
    assign owner_full = |(grant_q & out_full);

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .PTR_W    (PTR_W)
    ) u_arb (
        .elig     (elig),
        .ptr      (rr_ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // done is the only unregistered output: it must react to out_full in the same cycle.
    always_comb begin
        done = (state_q == DONE && !owner_full) ? grant_q : '0;
    end

    // Next-state logic for the job FSM, tap counter, drain counter and rr pointer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        tap_valid_d = 1'b0;
        tap_idx_d   = tap_idx_q;
        acc_clr_d   = 1'b0;
        tap_last_d  = 1'b0;
        busy_d      = busy_q;
        lat_d       = lat_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d     = ISSUE;
                    grant_d     = pick;
                    rr_ptr_d    = pick_idx;
                    tap_valid_d = 1'b1;
                    tap_idx_d   = '0;
                    acc_clr_d   = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ISSUE: begin
                if (tap_idx_q == LAST_IDX) begin
                    tap_idx_d = '0;
                    lat_d     = LAT_INIT;
                    state_d   = (MAC_LAT == 0) ? DONE : DRAIN;
                end else begin
                    tap_idx_d   = tap_idx_q + 1'b1;
                    tap_valid_d = 1'b1;
                    tap_last_d  = (tap_idx_q == LAST_IDX - 1'b1);
                end
            end
            DRAIN: begin
                if (lat_q == '0) begin
                    state_d = DONE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            DONE: begin
                // The owner keeps the MAC until its FIFO can accept the result.
                if (!owner_full) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FIR_SCHED_STATS_EN
    logic [31:0] job_count_q, job_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Statistics: completed jobs and DONE cycles lost to a full owner FIFO.
    always_comb begin
        job_count_d    = job_count_q + 32'(|done);
        stall_cycles_d = stall_cycles_q + 32'(state_q == DONE && owner_full);
    end

    // Statistics registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            job_count_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            job_count_q    <= job_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign job_count    = job_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

    // FSM state and registered outputs; reset aborts any job in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            acc_clr_q   <= 1'b0;
            tap_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            lat_q       <= '0;
            rr_ptr_q    <= PTR_W'(CHANNELS - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            tap_valid_q <= tap_valid_d;
            tap_idx_q   <= tap_idx_d;
            acc_clr_q   <= acc_clr_d;
            tap_last_q  <= tap_last_d;
            busy_q      <= busy_d;
            lat_q       <= lat_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign grant     = grant_q;
    assign tap_valid = tap_valid_q;
    assign tap_idx   = tap_idx_q;
    assign acc_clr   = acc_clr_q;
    assign tap_last  = tap_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler (CHANNELS=4, TAPS=20, MAC_LAT=2): directed
// sequences, a grant table, and random traffic against a job-level model.
module tb_fir_mac_scheduler;

    localparam int CH      = 4;
    localparam int TAPS    = 20;
    localparam int MAC_LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  out_full;
    logic [3:0]  grant;
    logic        tap_valid;
    logic [4:0]  tap_idx;
    logic        acc_clr;
    logic        tap_last;
    logic [3:0]  done;
    logic        busy;
`ifdef FIR_SCHED_STATS_EN
    logic [31:0] job_count;
    logic [31:0] stall_cycles;
`endif

    fir_mac_scheduler #(
        .CHANNELS (CH),
        .TAPS     (TAPS),
        .MAC_LAT  (MAC_LAT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .out_full     (out_full),
        .grant        (grant),
        .tap_valid    (tap_valid),
        .tap_idx      (tap_idx),
        .acc_clr      (acc_clr),
        .tap_last     (tap_last),
        .done         (done),
`ifdef FIR_SCHED_STATS_EN
        .job_count    (job_count),
        .stall_cycles (stall_cycles),
`endif
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    logic mdl_en = 1'b0;

    logic [16:0] outs_w;
    assign outs_w = {grant, tap_valid, tap_idx, acc_clr, tap_last, done, busy};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- job-level reference model ----------------
    // A job is "owner + cycles since grant"; everything else follows arithmetically.
    int          m_owner;
    int          m_ptr;
    int          m_t;
    logic [31:0] m_jobs;
    logic [31:0] m_stall;

    function automatic int pick_next(input logic [3:0] elig, input int ptr);
        for (int i = 1; i <= CH; i++) begin
            int c;
            c = (ptr + i) % CH;
            if (elig[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [16:0] model_outs();
        logic [3:0] g, d;
        logic       tv, cl, la, bz;
        logic [4:0] ix;
        g = '0; d = '0; tv = 1'b0; cl = 1'b0; la = 1'b0; bz = 1'b0; ix = '0;
        if (m_owner >= 0) begin
            g  = 4'(1 << m_owner);
            bz = 1'b1;
            tv = (m_t < TAPS);
            if (tv) begin
                ix = 5'(m_t);
                cl = (m_t == 0);
                la = (m_t == TAPS - 1);
            end
            if (m_t >= TAPS + MAC_LAT && !out_full[m_owner]) d = g;
        end
        return {g, tv, ix, cl, la, d, bz};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_owner <= -1;
            m_ptr   <= CH - 1;
            m_t     <= 0;
            m_jobs  <= '0;
            m_stall <= '0;
        end else if (m_owner < 0) begin
            if (pick_next(req & ~out_full, m_ptr) >= 0) begin
                m_owner <= pick_next(req & ~out_full, m_ptr);
                m_ptr   <= pick_next(req & ~out_full, m_ptr);
                m_t     <= 0;
            end
        end else if (m_t >= TAPS + MAC_LAT) begin
            if (!out_full[m_owner]) begin
                m_owner <= -1;
                m_jobs  <= m_jobs + 1;
            end else begin
                m_stall <= m_stall + 1;
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clock) begin
        if (mdl_en) begin
            chk("model_outs", 32'(outs_w), 32'(model_outs()));
`ifdef FIR_SCHED_STATS_EN
            chk("model_job_count", job_count, m_jobs);
            chk("model_stall_cycles", stall_cycles, m_stall);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench just after the posedge that starts cycle 0.
    task automatic do_reset();
        req      = '0;
        out_full = '0;
        reset    = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        next();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] full;
        logic [3:0] exp_grant;
    } vec_t;

    vec_t       tbl[6];
    logic [3:0] glog[$];
    int         gstart[$];
    logic [3:0] prevg;
    int         dcnt;

    initial begin
        tbl[0] = '{req: 4'b0110, full: 4'b0000, exp_grant: 4'b0010};
        tbl[1] = '{req: 4'b1000, full: 4'b0000, exp_grant: 4'b1000};
        tbl[2] = '{req: 4'b1111, full: 4'b0001, exp_grant: 4'b0010};
        tbl[3] = '{req: 4'b1100, full: 4'b1100, exp_grant: 4'b0000};
        tbl[4] = '{req: 4'b0101, full: 4'b0000, exp_grant: 4'b0001};
        tbl[5] = '{req: 4'b1010, full: 4'b0010, exp_grant: 4'b1000};

        req      = '0;
        out_full = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        mdl_en = 1'b1;

        // 1: idle after reset release
        do_reset();
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            chk("idle_outputs", 32'({grant, tap_valid, done, busy}), 32'h0);
            next();
        end

        // Grant table: first pick out of reset (ch0 has priority)
        for (int i = 0; i < 6; i++) begin
            do_reset();
            req      = tbl[i].req;
            out_full = tbl[i].full;
            @(negedge clock);
            next();
            req      = '0;
            out_full = '0;
            @(negedge clock);
            chk("tbl_grant", 32'(grant), 32'(tbl[i].exp_grant));
            chk("tbl_acc_clr", 32'(acc_clr), 32'(tbl[i].exp_grant != 0));
        end

        // 2: single job on ch1
        do_reset();
        req = 4'b0010;
        @(negedge clock);
        chk("t2_grant_c0", 32'(grant), 32'h0);
        next();
        req = '0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clock);
            if (c <= 20) begin
                chk("t2_grant", 32'(grant), 32'b0010);
                chk("t2_tap_valid", 32'(tap_valid), 32'd1);
                chk("t2_tap_idx", 32'(tap_idx), 32'(c - 1));
                chk("t2_acc_clr", 32'(acc_clr), 32'(c == 1));
                chk("t2_tap_last", 32'(tap_last), 32'(c == 20));
            end
            if (c == 22) chk("t2_done_early", 32'(done), 32'h0);
            if (c == 23) chk("t2_done", 32'(done), 32'b0010);
            if (c == 24) chk("t2_grant_clear", 32'(grant), 32'h0);
            next();
        end

        // 3: all requesting, round-robin rotation
        do_reset();
        req   = 4'b1111;
        prevg = '0;
        for (int c = 0; c <= 105; c++) begin
            @(negedge clock);
            if (grant != 0 && prevg == 0) begin
                glog.push_back(grant);
                gstart.push_back(c);
            end
            prevg = grant;
            next();
        end
        req = '0;
        chk("t3_num_grants", 32'(gstart.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] eg;
            eg = 4'(1 << (i % CH));
            if (i < gstart.size()) begin
                chk("t3_grant_seq", 32'(glog[i]), 32'(eg));
                chk("t3_grant_start", 32'(gstart[i]), 32'(1 + 24 * i));
            end
        end

        // 4: ch2 job stalled by its full FIFO
        do_reset();
        for (int c = 0; c <= 33; c++) begin
            req      = (c == 0) ? 4'b0100 : 4'b0000;
            out_full = (c >= 20 && c <= 30) ? 4'b0100 : 4'b0000;
            @(negedge clock);
            if (c >= 23 && c <= 30) chk("t4_done_held", 32'(done), 32'h0);
            if (c == 31) chk("t4_done", 32'(done), 32'b0100);
            if (c == 32) chk("t4_grant_clear", 32'(grant), 32'h0);
            next();
        end
`ifdef FIR_SCHED_STATS_EN
        chk("t4_stall_cycles", stall_cycles, 32'd8);
`endif

        // 5: reset mid-job at tap_idx 7
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req = (c == 0) ? 4'b0010 : 4'b0000;
            @(negedge clock);
            next();
        end
        #1;
        chk("t5_tap_idx_before", 32'(tap_idx), 32'd7);
        reset = 1'b1;
        #1;
        chk("t5_async_zero", 32'(outs_w), 32'h0);
        @(negedge clock);
        chk("t5_reset_outputs", 32'(outs_w), 32'h0);
        reset = 1'b0;
        next();
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            chk("t5_no_done", 32'({grant, done}), 32'h0);
            next();
        end
        req = 4'b0011;
        @(negedge clock);
        next();
        req = '0;
        @(negedge clock);
        chk("t5_restart_grant", 32'(grant), 32'b0001);
        chk("t5_restart_idx", 32'(tap_idx), 32'd0);
        chk("t5_restart_clr", 32'(acc_clr), 32'd1);
        next();

        // 6: ch3 blocked by out_full in IDLE, then three jobs
        do_reset();
        dcnt = 0;
        for (int c = 0; c < 5; c++) begin
            req      = 4'b1000;
            out_full = 4'b1000;
            @(negedge clock);
            chk("t6_blocked", 32'(grant), 32'h0);
            next();
        end
        out_full = '0;
        @(negedge clock);
        next();
        req = '0;
        @(negedge clock);
        chk("t6_grant_ch3", 32'(grant), 32'b1000);
        for (int j = 0; j < 3; j++) begin
            if (j == 1) req = 4'b0001;
            if (j == 2) req = 4'b0010;
            for (int c = 0; c < 30; c++) begin
                @(negedge clock);
                if (done != 0) dcnt++;
                next();
                req = '0;
            end
        end
        chk("t6_done_pulses", 32'(dcnt), 32'd3);
`ifdef FIR_SCHED_STATS_EN
        chk("t6_job_count", job_count, 32'd3);
`endif

        // Random traffic; the model checker compares every cycle.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            req      = 4'($urandom);
            out_full = 4'($urandom) & 4'($urandom);
            @(negedge clock);
            next();
        end

        mdl_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
